// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment scanner with double-buffered data.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module seg_scan_display #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [DIGITS-1:0]   led_en,
  output logic [6:0]          led_seg,
  output logic                led_dp,
  output logic                frame_done
);

  localparam int DW = 4 * DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     bcnt;
  logic              phase;

  logic [DW-1:0]     pend_data, shd_data;
  logic [DIGITS-1:0] pend_dp, shd_dp;
  logic [DIGITS-1:0] pend_blank, shd_blank;
  logic [DIGITS-1:0] pend_blink, shd_blink;

  logic              tick, started, boundary;
  logic [IW-1:0]     nidx;
  logic [DW-1:0]     nxt_data, src_data;
  logic [DIGITS-1:0] nxt_dp, src_dp;
  logic [DIGITS-1:0] nxt_blank, src_blank;
  logic [DIGITS-1:0] nxt_blink, src_blink;
  logic              src_phase;
  logic [DIGITS-1:0] lz;
  logic [3:0]        nib;
  logic              s_dp, s_blank, s_blink, s_lz;
  logic              dark;
  logic [6:0]        seg_n;
  logic              dp_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // led_en is all ones only before the first slot has been lit
  assign started  = ~&led_en;
  assign tick     = (presc == P_LAST);
  assign boundary = tick && started && (idx == I_LAST);

  always_comb begin
    nidx = '0;
    if (started && idx != I_LAST)
      nidx = IW'(idx + 1'b1);
  end

  assign nxt_data  = load ? data       : pend_data;
  assign nxt_dp    = load ? dp_mask    : pend_dp;
  assign nxt_blank = load ? blank_mask : pend_blank;
  assign nxt_blink = load ? blink_mask : pend_blink;

  // the slot starting on a boundary already belongs to the new frame
  assign src_data  = boundary ? nxt_data  : shd_data;
  assign src_dp    = boundary ? nxt_dp    : shd_dp;
  assign src_blank = boundary ? nxt_blank : shd_blank;
  assign src_blink = boundary ? nxt_blink : shd_blink;
  assign src_phase = (boundary && bcnt == B_LAST) ? ~phase : phase;

`ifdef LEADING_ZERO_BLANK_EN
  logic run;
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (run && src_data[4*i +: 4] == 4'h0)
        lz[i] = 1'b1;
      else
        run = 1'b0;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    nib     = '0;
    s_dp    = 1'b0;
    s_blank = 1'b0;
    s_blink = 1'b0;
    s_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nidx == IW'(i)) begin
        nib     = src_data[4*i +: 4];
        s_dp    = src_dp[i];
        s_blank = src_blank[i];
        s_blink = src_blink[i];
        s_lz    = lz[i];
      end
    end
  end

  assign dark  = s_blank | (s_blink & src_phase);
  assign seg_n = (dark | s_lz) ? 7'b1111111 : hex7(nib);
  assign dp_n  = dark ? 1'b1 : ~s_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      shd_data   <= '0;
      shd_dp     <= '0;
      shd_blank  <= '0;
      shd_blink  <= '0;
      led_en     <= '1;
      led_seg    <= 7'b1111111;
      led_dp     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      presc      <= tick ? '0 : PW'(presc + 1'b1);
      frame_done <= boundary;
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp_mask;
        pend_blank <= blank_mask;
        pend_blink <= blink_mask;
      end
      if (tick) begin
        idx     <= nidx;
        led_en  <= ~(DIGITS'(1) << nidx);
        led_seg <= seg_n;
        led_dp  <= dp_n;
      end
      if (boundary) begin
        shd_data  <= nxt_data;
        shd_dp    <= nxt_dp;
        shd_blank <= nxt_blank;
        shd_blink <= nxt_blink;
        if (bcnt == B_LAST) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= BW'(bcnt + 1'b1);
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multiplexed 7-segment display driver, the successor of the fixed 8-digit scanner. It drives DIGITS common-anode digits from a hex data word, with per-digit decimal point, blank and blink masks. Frames are tear-free: new data is double-buffered and applied only at frame boundaries. It sits between the CPU result/IO register and the board LED pins.

Parameters:
DIGITS, 8, number of digits scanned; legal range 2..16.
SCAN_DIV, 100000, clk cycles each digit stays lit; must be >= 2.
BLINK_FRAMES, 250, full frames per blink half-period; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
load  in  1  one-cycle strobe; captures data and the three masks
data  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i
dp_mask  in  DIGITS  1 = decimal point lit on digit i
blank_mask  in  DIGITS  1 = digit i fully dark
blink_mask  in  DIGITS  1 = digit i dark during the blink-off phase
led_en  out  DIGITS  digit enables, active-low, one-hot-zero
led_seg  out  7  segments {ca,cb,cc,cd,ce,cf,cg}, active-low
led_dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (rst_n low, async): led_en all 1, led_seg 7'b1111111, led_dp 1, frame_done 0, prescaler 0, digit index 0, pending and shadow registers 0, blink counter 0, blink phase 0.
- Prescaler counts 0..SCAN_DIV-1. tick = (prescaler == SCAN_DIV-1). Prescaler wraps to 0 on tick. Counter width is clog2(SCAN_DIV).
- On tick:
  - led_en, led_seg and led_dp are registered and update together in the same cycle, for the digit whose slot is starting.
  - The first tick after reset lights digit 0: led_en = ~(1<<0).
  - The index then advances 0,1,...,DIGITS-1 and wraps to 0. No dead digits for non-power-of-2 DIGITS.
- Frame boundary = tick while index == DIGITS-1:
  - frame_done pulses for 1 cycle.
  - pending -> shadow transfer occurs.
  - Blink counter increments. At BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- load:
  - Writes pending in the next cycle.
  - Multiple loads within a frame: the last one wins.
  - load in the same cycle as a frame boundary: the new values bypass straight into shadow.
- Output values come from shadow only:
  - Digit dark (led_seg 7'b1111111, led_dp 1) if blank_mask[i], or if blink_mask[i] and blink phase == 1.
  - Otherwise led_seg = hex decode of nibble i, and led_dp = ~dp_mask[i].
- Hex decode (active-low):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- Latency from load to visible: from 2 cycles (load on a boundary, bypass) up to DIGITS*SCAN_DIV+1 cycles.
- Reset mid-frame: everything returns to reset values immediately. Scanning restarts at digit 0 after SCAN_DIV cycles. Loads made before reset are lost.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - At each frame boundary, a leading-zero mask is computed from the incoming shadow data.
  - Digits from index DIGITS-1 downward are blanked while their nibble is 0, stopping at the first nonzero nibble.
  - Digit 0 is never blanked, so an all-zero value shows "0".
  - dp_mask still lights the DP on a zero-blanked digit.
- Undefined: all nibbles are displayed; no extra registers exist.

Test Plan:
- Reset, then run DIGITS=4, SCAN_DIV=4 for 20 cycles -> led_en sequence 1110, 1101, 1011, 0111, 1110. Each value is held 4 cycles. The first change occurs 4 cycles after reset release. frame_done pulses once per 16 cycles.
- load data=16'h1A20, dp_mask=4'b0100 mid-frame -> display unchanged until the next boundary. Then digit0 0000001, digit1 0010010, digit2 0001000 with led_dp=0, digit3 1001111.
- Two loads in one frame (16'h1111 then 16'h2222) -> only 2 is ever shown. load asserted on the boundary cycle -> its value is shown in the very next slot (bypass).
- BLINK_FRAMES=2, blink_mask=4'b0001, blank_mask=4'b1000 -> digit0 is dark on alternate 2-frame periods, digit3 is always dark, and digit1 and digit2 are never dark.
- DIGITS=3 (non-power-of-2) -> index wraps 2->0, and led_en never shows 3'b111 after the first tick.
- Assert rst_n low mid-slot, asynchronously -> outputs go to reset values in the same cycle. After release, digit 0 lights after SCAN_DIV cycles. With LEADING_ZERO_BLANK_EN and data=16'h0050 -> digits 3 and 2 are dark, digit1 shows 5, digit0 shows 0.
